// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, D/E stall/flush controls, E resolution inputs and predict/redirect outputs
interface branch_predictor_if;
  logic [31:0] PCF;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic        BranchE;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] PCPlus4E;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchMissed;
  logic [31:0] RedirectPCE;
  modport master (
    output PCF, StallF, StallD, FlushD, FlushE, BranchE, BranchTakenE, BranchTargetE, PCPlus4E,
    input  PredTakenF, PredTargetF, BranchMissed, RedirectPCE
  );
  modport slave (
    input  PCF, StallF, StallD, FlushD, FlushE, BranchE, BranchTakenE, BranchTargetE, PCPlus4E,
    output PredTakenF, PredTargetF, BranchMissed, RedirectPCE
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB + 2-bit counters; ports clk, reset, bp (PCF in -> PredTakenF/PredTargetF out, E inputs -> BranchMissed/RedirectPCE out)
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 26
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bp
);
  localparam int N = 1 << INDEX_BITS;
  logic [N-1:0]          valid_q;
  logic [TAG_BITS-1:0]   tag_q [N];
  logic [31:0]           tgt_q [N];
  logic [1:0]            ctr_q [N];
  logic                  fd_v_q, fd_t_q, fd_v_d, fd_t_d;
  logic [31:0]           fd_tg_q, fd_tg_d;
  logic                  de_v_q, de_t_q, de_v_d, de_t_d;
  logic [31:0]           de_tg_q, de_tg_d;
  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e, tk_e;
  logic [31:0]           pc_e;
  logic [1:0]            ctr_e, ctr_inc, ctr_dec;
  logic                  unused;
  assign idx_f = bp.PCF[INDEX_BITS+1:2];
  assign tag_f = bp.PCF[31:INDEX_BITS+2];
  assign hit_f = valid_q[idx_f] && tag_q[idx_f] == tag_f;
  assign bp.PredTakenF  = hit_f & ctr_q[idx_f][1];
  assign bp.PredTargetF = hit_f ? tgt_q[idx_f] : '0;
  assign pc_e  = bp.PCPlus4E - 32'd4;
  assign idx_e = pc_e[INDEX_BITS+1:2];
  assign tag_e = pc_e[31:INDEX_BITS+2];
  assign hit_e = valid_q[idx_e] && tag_q[idx_e] == tag_e;
  assign tk_e  = bp.BranchE & bp.BranchTakenE;
  assign ctr_e   = ctr_q[idx_e];
  assign ctr_inc = ctr_e == 2'b11 ? 2'b11 : ctr_e + 2'd1;
  assign ctr_dec = ctr_e == 2'b00 ? 2'b00 : ctr_e - 2'd1;
  assign unused  = ^{bp.StallF, bp.PCF[1:0], pc_e[1:0]};
  // non-branch predicted taken and branch predicted taken but not taken both redirect to fall-through
  assign bp.BranchMissed = de_v_q & (tk_e ? (!de_t_q || de_tg_q != bp.BranchTargetE) : de_t_q);
  assign bp.RedirectPCE  = bp.BranchMissed ? (tk_e ? bp.BranchTargetE : bp.PCPlus4E) : '0;
  always_comb begin
    fd_v_d  = bp.FlushD ? 1'b0 : bp.StallD ? fd_v_q  : 1'b1;
    fd_t_d  = bp.FlushD ? 1'b0 : bp.StallD ? fd_t_q  : bp.PredTakenF;
    fd_tg_d = bp.FlushD ? '0   : bp.StallD ? fd_tg_q : bp.PredTargetF;
    de_v_d  = bp.FlushE ? 1'b0 : fd_v_q;
    de_t_d  = bp.FlushE ? 1'b0 : fd_t_q;
    de_tg_d = bp.FlushE ? '0   : fd_tg_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {fd_v_q, fd_t_q, fd_tg_q} <= '0;
      {de_v_q, de_t_q, de_tg_q} <= '0;
    end else begin
      {fd_v_q, fd_t_q, fd_tg_q} <= {fd_v_d, fd_t_d, fd_tg_d};
      {de_v_q, de_t_q, de_tg_q} <= {de_v_d, de_t_d, de_tg_d};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (de_v_q) begin
      if (bp.BranchE && hit_e) begin
        ctr_q[idx_e] <= bp.BranchTakenE ? ctr_inc : ctr_dec;
        if (bp.BranchTakenE) tgt_q[idx_e] <= bp.BranchTargetE;
      end else if (bp.BranchE && bp.BranchTakenE) begin
        valid_q[idx_e] <= 1'b1;
        tag_q[idx_e]   <= tag_e;
        tgt_q[idx_e]   <= bp.BranchTargetE;
        ctr_q[idx_e]   <= 2'b10;
      end else if (!bp.BranchE && hit_e && de_t_q) begin
        valid_q[idx_e] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor
module tb_branch_predictor;
  localparam logic [31:0] IDLE = 32'h8000_0000;
  typedef struct {
    logic        v;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] pc4;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  ent_t q[$];
  logic        m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_ctr [16];
  branch_predictor_if bp();
  branch_predictor dut (.clk(clk), .reset(reset), .bp(bp));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic ent_t bubble(input ent_t e);
    ent_t b = e;
    b.v = 1'b0;
    b.pt = 1'b0;
    b.ptg = '0;
    return b;
  endfunction
  task automatic m_clear();
    ent_t b;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
      m_ctr[i] = 2'b01;
    end
    b = '{1'b0, 1'b0, 32'h0, IDLE + 4, 1'b0, 1'b0, 32'h0};
    q.delete();
    q.push_back(b);
    q.push_back(b);
  endtask
  task automatic predict(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
    int i = int'(pc[5:2]);
    logic h = m_v[i] && m_tag[i] == pc[31:6];
    pt = h && m_ctr[i][1];
    ptg = h ? m_tgt[i] : 32'h0;
  endtask
  task automatic m_update(input ent_t e);
    logic [31:0] pc = e.pc4 - 32'd4;
    int i = int'(pc[5:2]);
    logic h = m_v[i] && m_tag[i] == pc[31:6];
    if (!e.v) return;
    if (e.br && h && e.tk) begin
      if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'd1;
      m_tgt[i] = e.tgt;
    end else if (e.br && h) begin
      if (m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'd1;
    end else if (e.br && e.tk) begin
      m_v[i] = 1'b1;
      m_tag[i] = pc[31:6];
      m_tgt[i] = e.tgt;
      m_ctr[i] = 2'b10;
    end else if (!e.br && h && e.pt) begin
      m_v[i] = 1'b0;
    end
  endtask
  task automatic cyc(input logic [31:0] pc, input logic [31:0] pc4, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic sd, input logic fd, input logic fe);
    ent_t e, fdq, fn;
    logic pt, miss;
    logic [31:0] ptg, rd;
    @(negedge clk);
    e = q.pop_front();
    fdq = q.pop_front();
    bp.PCF = pc;
    bp.StallF = 1'($urandom_range(0, 1));
    bp.StallD = sd;
    bp.FlushD = fd;
    bp.FlushE = fe;
    bp.BranchE = e.br;
    bp.BranchTakenE = e.tk;
    bp.BranchTargetE = e.tgt;
    bp.PCPlus4E = e.pc4;
    #1;
    predict(pc, pt, ptg);
    chk("PredTakenF", 32'(bp.PredTakenF), 32'(pt));
    chk("PredTargetF", bp.PredTargetF, ptg);
    if (!e.v) miss = 1'b0;
    else if (e.br && e.tk) miss = !e.pt || e.ptg != e.tgt;
    else miss = e.pt;
    rd = !miss ? 32'h0 : (e.br && e.tk) ? e.tgt : e.pc4;
    chk("BranchMissed", 32'(bp.BranchMissed), 32'(miss));
    chk("RedirectPCE", bp.RedirectPCE, rd);
    m_update(e);
    fn = '{1'b1, pt, ptg, pc4, br, tk, tgt};
    q.push_back(fe ? bubble(fdq) : fdq);
    q.push_back(fd ? bubble(fn) : sd ? fdq : fn);
  endtask
  task automatic ins(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    cyc(pc, pc + 32'd4, br, tk, tgt, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) ins(IDLE, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    bp.PCF = 32'h100;
    bp.StallF = 1'b0;
    bp.StallD = 1'b0;
    bp.FlushD = 1'b0;
    bp.FlushE = 1'b0;
    bp.BranchE = 1'b0;
    bp.BranchTakenE = 1'b0;
    bp.BranchTargetE = 32'h0;
    bp.PCPlus4E = IDLE + 4;
    if (q.size() > 0) begin
      bp.BranchE = q[0].br;
      bp.BranchTakenE = q[0].tk;
      bp.BranchTargetE = q[0].tgt;
      bp.PCPlus4E = q[0].pc4;
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("rst_PredTakenF", 32'(bp.PredTakenF), 32'h0);
      chk("rst_PredTargetF", bp.PredTargetF, 32'h0);
      chk("rst_BranchMissed", 32'(bp.BranchMissed), 32'h0);
      chk("rst_RedirectPCE", bp.RedirectPCE, 32'h0);
    end
    reset = 1'b0;
    m_clear();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset(3);
    ins(32'h100, 1'b0, 1'b0, 32'h0);
    ins(32'h100, 1'b1, 1'b1, 32'h200);
    idle(2);
    for (int k = 0; k < 3; k++) begin
      ins(32'h100, 1'b1, 1'b0, 32'h0);
      idle(2);
    end
    for (int k = 0; k < 4; k++) begin
      ins(32'h100, 1'b1, 1'b1, 32'h200);
      idle(2);
    end
    ins(32'h100, 1'b1, 1'b0, 32'h0);
    idle(2);
    ins(32'h100, 1'b1, 1'b1, 32'h200);
    ins(32'h100, 1'b1, 1'b1, 32'h300);
    ins(32'h100, 1'b1, 1'b1, 32'h300);
    ins(32'h100, 1'b1, 1'b1, 32'h300);
    idle(2);
    ins(32'h100, 1'b0, 1'b0, 32'h0);
    cyc(IDLE, IDLE + 4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(2);
    ins(32'h100, 1'b1, 1'b1, 32'h999);
    cyc(IDLE, IDLE + 4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    ins(32'h100, 1'b1, 1'b1, 32'h300);
    idle(2);
    ins(32'h180, 1'b1, 1'b1, 32'h400);
    cyc(IDLE, IDLE + 4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(32'h100, 32'h144, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    ins(32'h100, 1'b0, 1'b0, 32'h0);
    idle(2);
    ins(32'h100, 1'b0, 1'b0, 32'h0);
    idle(2);
    ins(32'h200, 1'b1, 1'b1, 32'h500);
    ins(IDLE, 1'b0, 1'b0, 32'h0);
    do_reset(2);
    ins(32'h200, 1'b0, 1'b0, 32'h0);
    idle(2);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pcs [5];
      logic [31:0] pc, tgt;
      int r;
      pcs = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h2000};
      pc = pcs[$urandom_range(0, 4)];
      r = int'($urandom_range(0, 2));
      tgt = r == 0 ? 32'h200 : r == 1 ? 32'h300 : pc + 32'd8;
      cyc(pc, pc + 32'd4, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), tgt,
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
